// File: rtl/execute_instruction_pkg.sv
// Shared widths and opcode encodings for the execute stage.
package execute_instruction_pkg;

  localparam int unsigned DefWord = 32;
  localparam int unsigned DefWOpc = 6;
  localparam int unsigned DefWRd  = 4;
  localparam int unsigned DefAddr = 16;

  localparam logic [5:0] OpNop  = 6'd0;
  localparam logic [5:0] OpAdd  = 6'd1;
  localparam logic [5:0] OpSub  = 6'd2;
  localparam logic [5:0] OpAnd  = 6'd3;
  localparam logic [5:0] OpOr   = 6'd4;
  localparam logic [5:0] OpXor  = 6'd5;
  localparam logic [5:0] OpShl  = 6'd6;
  localparam logic [5:0] OpShr  = 6'd7;
  localparam logic [5:0] OpJmp  = 6'd8;
  localparam logic [5:0] OpBeqz = 6'd9;
  localparam logic [5:0] OpMul  = 6'd10;

endpackage

// File: rtl/execute_instruction_mul_iter.sv
// Iterative shift-add multiplier (mul_iter): one partial product per cycle, Width iterations.
module execute_instruction_mul_iter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] product_o
);

  localparam int unsigned CntW = $clog2(Width);

  logic [Width-1:0] a_q, b_q, acc_q, acc_d;
  logic [CntW-1:0]  cnt_q;

  assign acc_d     = b_q[0] ? acc_q + a_q : acc_q;
  assign done_o    = busy_o && (cnt_q == CntW'(Width - 1));
  // Product is presented combinationally on the final iteration so the caller can register it.
  assign product_o = acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_o <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else if (start_i) begin
      busy_o <= 1'b1;
      cnt_q  <= '0;
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
    end else if (busy_o) begin
      acc_q <= acc_d;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_o <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_instruction.sv
// Execute stage: 1-cycle ALU and branch resolution; iterative MUL when VENUS_MUL_EN is defined.
module execute_instruction
  import execute_instruction_pkg::*;
#(
  parameter int unsigned WORD  = DefWord,
  parameter int unsigned W_OPC = DefWOpc,
  parameter int unsigned W_RD  = DefWRd,
  parameter int unsigned ADDR  = DefAddr
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  output logic             stall_o,
  input  logic [W_OPC-1:0] opecode_i,
  input  logic [WORD-1:0]  opr0_i,
  input  logic [WORD-1:0]  opr1_i,
  input  logic [W_RD-1:0]  wb_r_i,
  output logic             wb_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic [WORD-1:0]  result_o,
  output logic             branch_o,
  output logic [ADDR-1:0]  branch_addr_o
);

  logic            accept;
  logic            alu_wb;
  logic [WORD-1:0] alu_res;
  logic            br_take;
  logic [ADDR-1:0] br_tgt;
`ifdef VENUS_MUL_EN
  logic            mul_op;
`endif

  // A visible branch squashes whatever decode presents in the same cycle.
  assign accept = v_i & ~stall_o & ~branch_o;

  always_comb begin
    alu_wb  = 1'b0;
    alu_res = '0;
    br_take = 1'b0;
    br_tgt  = '0;
`ifdef VENUS_MUL_EN
    mul_op  = 1'b0;
`endif
    case (opecode_i)
      W_OPC'(OpNop): ;
      W_OPC'(OpAdd): begin alu_wb = 1'b1; alu_res = opr0_i + opr1_i;       end
      W_OPC'(OpSub): begin alu_wb = 1'b1; alu_res = opr0_i - opr1_i;       end
      W_OPC'(OpAnd): begin alu_wb = 1'b1; alu_res = opr0_i & opr1_i;       end
      W_OPC'(OpOr):  begin alu_wb = 1'b1; alu_res = opr0_i | opr1_i;       end
      W_OPC'(OpXor): begin alu_wb = 1'b1; alu_res = opr0_i ^ opr1_i;       end
      W_OPC'(OpShl): begin alu_wb = 1'b1; alu_res = opr0_i << opr1_i[4:0]; end
      W_OPC'(OpShr): begin alu_wb = 1'b1; alu_res = opr0_i >> opr1_i[4:0]; end
      W_OPC'(OpJmp): begin br_take = 1'b1; br_tgt = opr0_i[ADDR-1:0];      end
      W_OPC'(OpBeqz): begin
        if (opr0_i == '0) begin
          br_take = 1'b1;
          br_tgt  = opr1_i[ADDR-1:0];
        end
      end
`ifdef VENUS_MUL_EN
      W_OPC'(OpMul): mul_op = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef VENUS_MUL_EN
  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StMulBusy = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [W_RD-1:0] mul_rd_q;
  logic            mul_start, mul_busy, mul_done;
  logic [WORD-1:0] mul_product;

  assign mul_start = accept & mul_op;
  assign stall_o   = (state_q == StMulBusy);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (mul_start) state_d = StMulBusy;
      StMulBusy: if (mul_done || !mul_busy) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mul_rd_q <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) mul_rd_q <= wb_r_i;
    end
  end

  execute_instruction_mul_iter #(
    .Width(WORD)
  ) u_mul_iter (
    .clk      (clk),
    .reset    (reset),
    .start_i  (mul_start),
    .a_i      (opr0_i),
    .b_i      (opr1_i),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );
`else
  assign stall_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_o          <= 1'b0;
      branch_o      <= 1'b0;
      wb_r_o        <= '0;
      result_o      <= '0;
      branch_addr_o <= '0;
    end else begin
      wb_o     <= 1'b0;
      branch_o <= 1'b0;
      if (accept && alu_wb) begin
        wb_o     <= 1'b1;
        wb_r_o   <= wb_r_i;
        result_o <= alu_res;
      end
      if (accept && br_take) begin
        branch_o      <= 1'b1;
        branch_addr_o <= br_tgt;
      end
`ifdef VENUS_MUL_EN
      // No instruction is accepted while busy, so this never collides with an ALU writeback.
      if (mul_done) begin
        wb_o     <= 1'b1;
        wb_r_o   <= mul_rd_q;
        result_o <= mul_product;
      end
`endif
    end
  end

endmodule

// File: tb/tb_execute_instruction.sv
// Scoreboard bench for execute_instruction; adapts expectations to VENUS_MUL_EN.
module tb_execute_instruction;

`ifdef VENUS_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v_i = 1'b0;
  logic        stall_o;
  logic [5:0]  opecode_i = '0;
  logic [31:0] opr0_i = '0;
  logic [31:0] opr1_i = '0;
  logic [3:0]  wb_r_i = '0;
  logic        wb_o;
  logic [3:0]  wb_r_o;
  logic [31:0] result_o;
  logic        branch_o;
  logic [15:0] branch_addr_o;

  execute_instruction dut (
    .clk          (clk),
    .reset        (reset),
    .v_i          (v_i),
    .stall_o      (stall_o),
    .opecode_i    (opecode_i),
    .opr0_i       (opr0_i),
    .opr1_i       (opr1_i),
    .wb_r_i       (wb_r_i),
    .wb_o         (wb_o),
    .wb_r_o       (wb_r_o),
    .result_o     (result_o),
    .branch_o     (branch_o),
    .branch_addr_o(branch_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_br;
    logic [3:0]  rd;
    logic [31:0] data;
    logic [15:0] addr;
  } evt_t;

  evt_t q[$];
  bit   exp_stall[int];
  bit   exp_zero[int];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;

  // Model state as seen by the driver for the current cycle.
  int   stall_left = 0;
  bit   branch_now = 1'b0;

  logic [3:0]  last_rd  = '0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input bit v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] rd);
    evt_t e;
    int   kind;
    int   k;
    bit   acc;
    k = cyc;
    v_i = v; opecode_i = op; opr0_i = a; opr1_i = b; wb_r_i = rd;
    acc  = v && (stall_left == 0) && !branch_now;
    kind = 0;
    e.cyc = k + 1; e.is_br = 1'b0; e.rd = rd; e.data = '0; e.addr = '0;
    if (acc) begin
      case (op)
        6'd1: begin kind = 1; e.data = a + b; end
        6'd2: begin kind = 1; e.data = a - b; end
        6'd3: begin kind = 1; e.data = a & b; end
        6'd4: begin kind = 1; e.data = a | b; end
        6'd5: begin kind = 1; e.data = a ^ b; end
        6'd6: begin kind = 1; e.data = a << b[4:0]; end
        6'd7: begin kind = 1; e.data = a >> b[4:0]; end
        6'd8: begin kind = 2; e.addr = a[15:0]; end
        6'd9: if (a == 0) begin kind = 2; e.addr = b[15:0]; end
        6'd10: if (MulEn) begin kind = 3; e.data = a * b; e.cyc = k + 33; end
        default: kind = 0;
      endcase
    end
    if (kind == 2) e.is_br = 1'b1;
    if (kind != 0) q.push_back(e);
    if (kind == 3) stall_left = 32;
    else if (stall_left > 0) stall_left--;
    branch_now = (kind == 2);
    exp_stall[k+1] = (stall_left > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v_i = 1'b1; opecode_i = 6'd1; opr0_i = $urandom; opr1_i = $urandom; wb_r_i = 4'd9;
    @(posedge clk);
    #1;
    q.delete();
    stall_left = 0;
    branch_now = 1'b0;
    exp_zero[cyc]  = 1'b1;
    exp_stall[cyc] = 1'b0;
    started = 1'b1;
    reset = 1'b0;
    v_i = 1'b0;
  endtask

  always @(negedge clk) begin
    evt_t e;
    if (started) begin
      if (exp_zero.exists(cyc)) begin
        chk("rst_outs", {stall_o, wb_o, branch_o, wb_r_o, result_o, branch_addr_o}, '0);
        last_rd  = '0;
        last_res = '0;
      end
      if (exp_stall.exists(cyc)) chk("stall", stall_o, exp_stall[cyc]);
      chk("wb_br_excl", wb_o & branch_o, 0);
      if (wb_o === 1'b1 || branch_o === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {wb_o, branch_o}, 0);
        end else begin
          e = q.pop_front();
          chk("evt_cycle", cyc, e.cyc);
          chk("evt_kind", {wb_o, branch_o}, e.is_br ? 2'b01 : 2'b10);
          if (e.is_br) begin
            chk("br_addr", branch_addr_o, e.addr);
          end else begin
            chk("wb_rd", wb_r_o, e.rd);
            chk("wb_data", result_o, e.data);
            last_rd  = e.rd;
            last_res = e.data;
          end
        end
      end else begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          chk("missed_evt", {wb_o, branch_o}, e.is_br ? 2'b01 : 2'b10);
        end
        chk("hold_rd", wb_r_o, last_rd);
        chk("hold_res", result_o, last_res);
      end
    end
  end

  initial begin
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    issue(1, 6'd1, 32'h7FFF_FFFF, 32'h1, 4'd2);
    issue(1, 6'd2, 32'h0, 32'h1, 4'd3);
    issue(1, 6'd6, 32'h1, 32'h21, 4'd5);
    issue(1, 6'd8, 32'h0040, 32'h0, 4'd0);
    issue(1, 6'd1, 32'h1, 32'h1, 4'd6);
    issue(1, 6'd9, 32'h5, 32'h0010, 4'd0);
    issue(1, 6'd9, 32'h0, 32'h0010, 4'd0);
    issue(0, 6'd0, 32'h0, 32'h0, 4'd0);
    issue(1, 6'd7, 32'h8000_0000, 32'hFFFF_FFE4, 4'd8);
    issue(1, 6'd10, 32'h89ab_cdef, 32'h3, 4'd4);
    repeat (34) issue(1, 6'd1, $urandom, $urandom, 4'd1);
    issue(1, 6'd10, 32'h1234_5678, 32'h9abc_def1, 4'd7);
    repeat (10) issue(0, 6'd3, $urandom, $urandom, 4'd0);
    do_reset();
    repeat (40) issue(0, 6'd0, 32'h0, 32'h0, 4'd0);
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        a = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        issue($urandom_range(0, 3) != 0, 6'($urandom_range(0, 15)), a, $urandom,
              4'($urandom_range(0, 15)));
      end
    end
    repeat (40) issue(0, 6'd0, 32'h0, 32'h0, 4'd0);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_instruction.md
EXECUTE_INSTRUCTION -- requirements
Module: execute_instruction

Interface
REQ-001 SHALL have parameters: WORD, default 32, datapath width; W_OPC, default 6, opcode width; W_RD, default 4, destination-register index width; ADDR, default 16, instruction address width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 v_i  input  1  opecode_i/opr0_i/opr1_i/wb_r_i are valid this cycle (from decode v_o).
REQ-005 stall_o  output  1  execute cannot accept; drives decode stall_i.
REQ-006 opecode_i  input  W_OPC  operation code.
REQ-007 opr0_i, opr1_i  input  WORD each  source operands.
REQ-008 wb_r_i  input  W_RD  destination register index.
REQ-009 wb_o  output  1  one-cycle writeback strobe (to decode wb_i).
REQ-010 wb_r_o  output  W_RD  writeback register index (to decode wb_r_i).
REQ-011 result_o  output  WORD  writeback data (to decode result_i).
REQ-012 branch_o  output  1  one-cycle taken-branch strobe (to fetch branch).
REQ-013 branch_addr_o  output  ADDR  branch target (to fetch branch_addr).

Function
REQ-014 SHALL accept an instruction on a rising edge where v_i=1, stall_o=0 and no squash is pending.
REQ-015 SHALL decode opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR (logical), 8 JMP, 9 BEQZ, 10 MUL; any other opcode executes as NOP.
REQ-016 ALU ops (1-7) SHALL assert wb_o, wb_r_o=wb_r_i and result_o for exactly the one cycle after acceptance (latency 1).
REQ-017 ADD/SUB/MUL SHALL wrap modulo 2^WORD; SHL/SHR shift opr0 by opr1[4:0]; opr1 bits above [4:0] are ignored.
REQ-018 JMP SHALL assert branch_o with branch_addr_o=opr0_i[ADDR-1:0] for the one cycle after acceptance; no writeback.
REQ-019 BEQZ SHALL behave as JMP to opr1_i[ADDR-1:0] when opr0_i==0; otherwise NOP.
REQ-020 Squash: an instruction presented with v_i=1 during a cycle when branch_o=1 SHALL be consumed and discarded (no wb, no branch, no state change).
REQ-021 States: IDLE (accepting), MUL_BUSY (iterating); IDLE->MUL_BUSY on MUL acceptance; MUL_BUSY->IDLE after the 32nd iteration.
REQ-022 stall_o SHALL equal 1 exactly while state=MUL_BUSY; otherwise 0.
REQ-023 MUL accepted at edge N SHALL occupy MUL_BUSY for 32 cycles and assert wb_o with the low WORD bits of opr0*opr1 in the cycle after the last iteration; stall_o is 0 in that cycle and a new instruction may be accepted in it.
REQ-024 Operands and wb_r_i SHALL be captured at acceptance; input changes during MUL_BUSY SHALL NOT affect the result.
REQ-025 wb_o and branch_o SHALL never be asserted in the same cycle.
REQ-026 When wb_o=0, wb_r_o and result_o SHALL hold their previous values.

Reset
REQ-027 reset=1 at a rising edge SHALL force state=IDLE, stall_o=0, wb_o=0, branch_o=0, wb_r_o=0, result_o=0, branch_addr_o=0 and clear any pending squash.
REQ-028 reset during MUL_BUSY SHALL abort the multiply with no writeback, and reset SHALL take priority over a simultaneous v_i.

Configuration
REQ-029 With macro VENUS_MUL_EN defined, MUL SHALL behave per REQ-021..REQ-024.
REQ-030 Without VENUS_MUL_EN, opcode 10 SHALL execute as NOP, MUL_BUSY is absent and stall_o SHALL be tied to 0.

Structure
REQ-031 Opcode constants and the WORD/W_OPC/W_RD/ADDR widths SHALL live in the shared include/params.v.
REQ-032 The iterative multiplier SHALL be a sub-module mul_iter (start, busy, done, 32-bit operands, 32-bit product), instantiated only under VENUS_MUL_EN.

Verification
REQ-033 ADD with opr0=0x7FFFFFFF, opr1=1, wb_r=2 -> wb_o=1 next cycle, result_o=0x80000000, wb_r_o=2.
REQ-034 SUB with opr0=0, opr1=1 -> result_o=0xFFFFFFFF; SHL with opr0=1, opr1=0x21 -> result_o=2.
REQ-035 JMP with opr0=0x0040, followed by ADD on the next cycle -> branch_o=1 with branch_addr_o=0x0040; the ADD produces no wb_o.
REQ-036 BEQZ with opr0=5 -> no branch_o; BEQZ with opr0=0, opr1=0x0010 -> branch_o=1, branch_addr_o=0x0010.
REQ-037 MUL (VENUS_MUL_EN) with opr0=0x89abcdef, opr1=3, wb_r=4 -> stall_o high 32 cycles, then wb_o=1, result_o=0x9d0369cd, wb_r_o=4; a held v_i is accepted in that cycle.
REQ-038 reset asserted at iteration 10 of a MUL -> next cycle stall_o=0, wb_o=0, all outputs 0; no later wb_o.
